uart_rx: RTL

- UART receiver: the downstream partner of uart_tx, recovering 8N1 frames from the serial line.
- Synchronises the asynchronous RX pin, detects the start bit, samples each bit at mid-bit, checks the stop bit and presents the byte with a one-cycle valid strobe.
- Uses the same runtime prescaler convention as uart_tx, so both ends of a loopback share one baud setting.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART pair: FSM encodings and prescaler limits.
// uart_tx imports the same package so both ends agree on the baud convention.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

    localparam int MIN_PRESC           = 4;
    localparam int DEFAULT_PRESC_WIDTH = 21;
    localparam int DATA_BITS           = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Flops reset to RESET_VAL so an idle-high line reads as idle straight out of reset.
module uart_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("uart_rx_sync needs at least two stages");
        end
    endgenerate

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit detect, mid-bit sampling, stop-bit check.
// State | meaning
// IDLE  | waiting for a falling edge on the synchronised line (only when armed)
// START | counting half a bit, then confirming the start bit is still low
// DATA  | sampling eight data bits LSB first, one per bit time
// STOP  | sampling the stop bit; high gives rx_valid, low gives frame_error
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int PRESC_WIDTH = DEFAULT_PRESC_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   RX,
    input  logic [PRESC_WIDTH-1:0] prescaler_in,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic                   rx_active
);

    logic rx_s;

    uart_rx_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .CLK  (CLK),
        .rst  (rst),
        .din  (RX),
        .dout (rx_s)
    );

    uart_state_t            state_q, state_d;
    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESC_WIDTH-1:0] nl_q, nl_d;
    logic [PRESC_WIDTH-1:0] presc_clamped;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   armed_q, armed_d;
    logic                   cnt_zero;

    assign presc_clamped = (prescaler_in < PRESC_WIDTH'(MIN_PRESC)) ?
                           PRESC_WIDTH'(MIN_PRESC) : prescaler_in;
    assign cnt_zero      = (cnt_q == '0);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            nl_q          <= PRESC_WIDTH'(MIN_PRESC);
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nl_q          <= nl_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            armed_q       <= armed_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nl_d          = nl_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        armed_d       = armed_q;

        unique case (state_q)
            ST_IDLE: begin
                // Arming needs a high line first, so a break cannot retrigger.
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    nl_d    = presc_clamped;
                    cnt_d   = (presc_clamped >> 1) - PRESC_WIDTH'(1);
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_zero) begin
                    if (!rx_s) begin
                        cnt_d     = nl_q - PRESC_WIDTH'(1);
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PRESC_WIDTH'(1);
                end
            end

            ST_DATA: begin
                if (cnt_zero) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = nl_q - PRESC_WIDTH'(1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - PRESC_WIDTH'(1);
                end
            end

            ST_STOP: begin
                if (cnt_zero) begin
                    rx_data_d = shift_q;
                    state_d   = ST_IDLE;
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                        armed_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - PRESC_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign rx_active   = (state_q != ST_IDLE);

endmodule
